// File: rtl/result_collector.sv
// Result collector: small FIFO of signed result words plus running
// count/sum/min/max statistics over every accepted word.
module result_collector #(
  parameter int DEPTH = 4,
  parameter int SUM_W = 40
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              y,
  input  logic                     clear,
  output logic                     drain_valid,
  input  logic                     drain_ready,
  output logic [31:0]              drain_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic [15:0]              count,
  output logic [SUM_W-1:0]         sum,
  output logic [31:0]              min_y,
  output logic [31:0]              max_y,
  output logic                     stat_valid
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [31:0]    mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           push;
  logic           pop;
  logic [LW-1:0]  level_nxt;
  logic [SUM_W-1:0] y_ext;
  logic           fresh;

  assign push        = in_valid & in_ready;
  assign pop         = drain_valid & drain_ready;
  assign drain_valid = (level != '0);
  assign drain_data  = mem[rd_ptr];
  assign level_nxt   = level + LW'(push) - LW'(pop);
  assign y_ext       = {{(SUM_W-32){y[31]}}, y};
  assign fresh       = clear | ~stat_valid;

  // in_ready is registered from the next occupancy, so a pop never
  // opens a push slot in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      in_ready <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= y;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      level    <= level_nxt;
      in_ready <= (level_nxt != LW'(DEPTH));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count      <= '0;
      sum        <= '0;
      min_y      <= '0;
      max_y      <= '0;
      stat_valid <= 1'b0;
    end else if (push) begin
      stat_valid <= 1'b1;
      if (fresh) begin
        count <= 16'd1;
        sum   <= y_ext;
        min_y <= y;
        max_y <= y;
      end else begin
        count <= count + 16'd1;
        sum   <= sum + y_ext;
        if ($signed(y) < $signed(min_y)) min_y <= y;
        if ($signed(y) > $signed(max_y)) max_y <= y;
      end
    end else if (clear) begin
      count      <= '0;
      sum        <= '0;
      min_y      <= '0;
      max_y      <= '0;
      stat_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_result_collector.sv
// Directed bench for result_collector with a queue-based reference
// model compared on every falling edge.
module tb_result_collector;

  localparam int DEPTH = 4;
  localparam int SUM_W = 40;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      y = '0;
  logic             clear = 1'b0;
  logic             drain_valid;
  logic             drain_ready = 1'b0;
  logic [31:0]      drain_data;
  logic [LW-1:0]    level;
  logic [15:0]      count;
  logic [SUM_W-1:0] sum;
  logic [31:0]      min_y;
  logic [31:0]      max_y;
  logic             stat_valid;

  result_collector #(.DEPTH(DEPTH), .SUM_W(SUM_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .y(y),
    .clear(clear),
    .drain_valid(drain_valid), .drain_ready(drain_ready),
    .drain_data(drain_data), .level(level),
    .count(count), .sum(sum), .min_y(min_y), .max_y(max_y),
    .stat_valid(stat_valid)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t",
                  name, act, exp, $time);
  endtask

  // Reference model: plain queue plus arithmetic statistics
  logic [31:0]      q[$];
  logic             m_rdy = 1'b0;
  int unsigned      m_cnt = 0;
  logic [SUM_W-1:0] m_sum = '0;
  logic [31:0]      m_min = '0;
  logic [31:0]      m_max = '0;
  logic             m_sv  = 1'b0;

  task automatic model_reset();
    q.delete();
    m_rdy = 1'b0;
    m_cnt = 0;
    m_sum = '0;
    m_min = '0;
    m_max = '0;
    m_sv  = 1'b0;
  endtask

  always @(negedge rst) model_reset();

  always @(posedge clk) begin
    if (!rst) model_reset();
    else begin
      automatic bit acc = in_valid && m_rdy;
      automatic bit pp  = (q.size() != 0) && drain_ready;
      if (pp) void'(q.pop_front());
      if (acc) q.push_back(y);
      if (clear) begin
        m_cnt = 0; m_sum = '0; m_min = '0; m_max = '0; m_sv = 1'b0;
      end
      if (acc) begin
        m_cnt = (m_cnt + 1) % 65536;
        m_sum = m_sum + SUM_W'($signed(y));
        if (!m_sv || $signed(y) < $signed(m_min)) m_min = y;
        if (!m_sv || $signed(y) > $signed(m_max)) m_max = y;
        m_sv = 1'b1;
      end
      m_rdy = (q.size() != DEPTH);
    end
  end

  always @(negedge clk) begin
    chk("level", 64'(level), 64'(q.size()));
    chk("in_ready", 64'(in_ready), 64'(m_rdy));
    chk("drain_valid", 64'(drain_valid), 64'(q.size() != 0));
    if (q.size() != 0) chk("drain_data", 64'(drain_data), 64'(q[0]));
    chk("count", 64'(count), 64'(m_cnt));
    chk("sum", 64'(sum), 64'(m_sum));
    chk("min_y", 64'(min_y), 64'(m_min));
    chk("max_y", 64'(max_y), 64'(m_max));
    chk("stat_valid", 64'(stat_valid), 64'(m_sv));
  end

  task automatic cyc(input logic iv, input logic [31:0] yy,
                     input logic dr, input logic cl);
    in_valid    = iv;
    y           = yy;
    drain_ready = dr;
    clear       = cl;
    @(negedge clk);
    #1;
  endtask

  initial begin
    #1;
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_drain_data", 64'(drain_data), 64'd0);
    @(negedge clk); #1;
    @(negedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("in_ready_after_release", 64'(in_ready), 64'd1);
    @(negedge clk); #1;

    // Reset pulse between edges with words buffered
    cyc(1, 32'd11, 0, 0);
    cyc(1, 32'd22, 0, 0);
    cyc(1, 32'd33, 0, 0);
    in_valid = 1'b0;
    chk("pre_rst_level", 64'(level), 64'd3);
    #1 rst = 1'b0;
    #1;
    chk("async_level", 64'(level), 64'd0);
    chk("async_drain_valid", 64'(drain_valid), 64'd0);
    chk("async_drain_data", 64'(drain_data), 64'd0);
    chk("async_count", 64'(count), 64'd0);
    chk("async_sum", 64'(sum), 64'd0);
    chk("async_in_ready", 64'(in_ready), 64'd0);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    chk("in_ready_one_edge", 64'(in_ready), 64'd1);
    @(negedge clk); #1;

    // Fill and stall
    cyc(1, 32'd5, 0, 0);
    cyc(1, 32'hFFFFFFF9, 0, 0);
    cyc(1, 32'd100, 0, 0);
    cyc(1, 32'hFFFF8000, 0, 0);
    cyc(1, 32'd9, 0, 0);
    chk("full_level", 64'(level), 64'd4);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    chk("full_count", 64'(count), 64'd4);
    chk("full_sum", 64'(sum), 64'($unsigned(SUM_W'(-32670))));
    chk("full_min", 64'(min_y), 64'h0000_0000_FFFF_8000);
    chk("full_max", 64'(max_y), 64'd100);

    // Full with simultaneous pop
    cyc(1, 32'd9, 1, 0);
    chk("pop_no_push_level", 64'(level), 64'd3);
    chk("pop_head", 64'(drain_data), 64'h0000_0000_FFFF_FFF9);
    cyc(1, 32'd9, 0, 0);
    chk("next_push_level", 64'(level), 64'd4);
    chk("next_push_count", 64'(count), 64'd5);

    // Clear coinciding with accept
    cyc(0, 32'd0, 1, 0);
    cyc(1, 32'hFFFFFFFD, 0, 1);
    chk("clr_count", 64'(count), 64'd1);
    chk("clr_sum", 64'(sum), 64'($unsigned(SUM_W'(-3))));
    chk("clr_min", 64'(min_y), 64'h0000_0000_FFFF_FFFD);
    chk("clr_max", 64'(max_y), 64'h0000_0000_FFFF_FFFD);
    chk("clr_level", 64'(level), 64'd4);
    chk("clr_head", 64'(drain_data), 64'd100);
    repeat (4) cyc(0, 32'd0, 1, 0);
    chk("drained_level", 64'(level), 64'd0);

    // Streaming extremes
    cyc(0, 32'd0, 0, 1);
    cyc(1, 32'h7FFFFFFF, 1, 0);
    chk("stream_head0", 64'(drain_data), 64'h0000_0000_7FFF_FFFF);
    cyc(1, 32'h80000000, 1, 0);
    chk("stream_head1", 64'(drain_data), 64'h0000_0000_8000_0000);
    chk("stream_level", 64'(level), 64'd1);
    cyc(0, 32'd0, 1, 0);
    chk("stream_sum", 64'(sum), 64'($unsigned(SUM_W'(-1))));
    chk("stream_empty", 64'(level), 64'd0);

    // Counter wrap
    cyc(0, 32'd0, 0, 1);
    repeat (65536) cyc(1, 32'd1, 1, 0);
    cyc(0, 32'd0, 1, 0);
    chk("wrap_count", 64'(count), 64'd0);
    chk("wrap_sum", 64'(sum), 64'd65536);
    chk("wrap_level", 64'(level), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/result_collector.md
RESULT_COLLECTOR -- requirements
Module: result_collector

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the number of FIFO entries (power of two, 2..16).
REQ-002 Parameter SUM_W, default 40, SHALL set the width of the running-sum accumulator.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on the rising edge.
REQ-004 rst  input  1  SHALL be an asynchronous, active-low reset.
REQ-005 in_valid  input  1  SHALL flag that the upstream result on y is valid.
REQ-006 in_ready  output  1  SHALL flag that the collector can accept a result this cycle.
REQ-007 y  input  32  SHALL carry a signed two's-complement result word.
REQ-008 clear  input  1  SHALL synchronously clear the statistics only.
REQ-009 drain_valid  output  1  SHALL flag that drain_data holds the oldest buffered result.
REQ-010 drain_ready  input  1  SHALL flag that the downstream reader takes drain_data this cycle.
REQ-011 drain_data  output  32  SHALL present the FIFO head word.
REQ-012 level  output  clog2(DEPTH)+1  SHALL report the FIFO occupancy.
REQ-013 count  output  16  SHALL report the number of results accepted since reset or clear.
REQ-014 sum  output  SUM_W  SHALL report the signed running sum of accepted results.
REQ-015 min_y, max_y  output  32 each  SHALL report the signed extremes of accepted results.
REQ-016 stat_valid  output  1  SHALL flag that min_y and max_y hold at least one sample.

Function
REQ-017 A result SHALL be accepted exactly when in_valid=1 and in_ready=1 at a rising edge.
REQ-018 in_ready SHALL equal (level != DEPTH) and SHALL be driven from registered state only (no combinational path from drain_ready).
REQ-019 When full, a same-cycle pop SHALL NOT enable a push; the push becomes possible on the next cycle.
REQ-020 drain_valid SHALL equal (level != 0), and drain_data SHALL be the registered head entry.
REQ-021 A pop SHALL occur exactly when drain_valid=1 and drain_ready=1.
REQ-022 Latency SHALL be 1 cycle: a word accepted at edge N is visible on drain_data after edge N when the FIFO was empty.
REQ-023 Words SHALL drain in strict acceptance order; read and write pointers SHALL wrap modulo DEPTH.
REQ-024 A push and a pop in the same cycle SHALL leave level unchanged and SHALL preserve order.
REQ-025 drain_data SHALL hold stable while drain_valid=1 and drain_ready=0.
REQ-026 Per accepted word: count SHALL increment, wrapping 0xFFFF->0x0000.
REQ-027 Per accepted word: sum SHALL add sign-extended y and wrap modulo 2^SUM_W.
REQ-028 Per accepted word, the first sample after reset or clear SHALL load both min_y and max_y and set stat_valid=1; later samples SHALL update them by signed compare.
REQ-029 clear=1 SHALL zero count, sum, min_y, max_y and stat_valid, and SHALL NOT affect the FIFO contents, level or pointers.
REQ-030 If clear=1 coincides with an accept, the statistics SHALL reflect that word alone: count=1, sum=y, min_y=max_y=y, stat_valid=1.
REQ-031 in_valid while in_ready=0 SHALL be ignored, with no state change.
REQ-032 Outputs count, sum, min_y, max_y, stat_valid and level SHALL update one cycle after the qualifying edge.

Reset
REQ-033 While rst=0, the block SHALL hold: level=0, in_ready=0, drain_valid=0, drain_data=0, count=0, sum=0, min_y=0, max_y=0, stat_valid=0, and pointers at 0.
REQ-034 Reset assertion mid-transfer SHALL discard all buffered words immediately, without waiting for a clock edge.
REQ-035 in_ready SHALL rise on the first clock edge after rst deasserts.

Verification
REQ-036 Reset check: push 3 words, pulse rst=0 between edges -> all outputs zero at once; in_ready=1 one edge after release.
REQ-037 Fill and stall: drain_ready=0, push 5, -7, 100, -32768, then offer 9 -> 9 refused, in_ready=0, level=4; sum=-32670, min_y=-32768, max_y=100.
REQ-038 Full with simultaneous pop: full FIFO, drain_ready=1, in_valid=1 with 9 -> pop 5, no push, level=3; next edge 9 accepted, level=4.
REQ-039 Streaming: drain_ready=1, push 0x7FFFFFFF and 0x80000000 back-to-back -> both drain in order with 1-cycle latency; sum=-1, level stays at most 1.
REQ-040 Clear with accept: clear=1 while accepting -3 -> count=1, sum=-3, min_y=max_y=-3; FIFO words preserved.
REQ-041 Wrap: 65536 accepts of y=1 -> count=0, sum=65536, pointers wrap with order preserved.
